// File: rtl/shift_ctrl_pkg.sv
// Purpose : shared types and constants for the shift sequencer and its register.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Holds the operation and FSM encodings, the register mode constants
// (written as {s0,s1}) and the default datapath width.
package shift_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        OP_LSL  = 3'b000,
        OP_LSR  = 3'b001,
        OP_ASR  = 3'b010,
        OP_ROL  = 3'b011,
        OP_ROR  = 3'b100,
        OP_PASS = 3'b101
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } sr_state_e;

    // Register mode selects, packed as {s0,s1}.
    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_SHR  = 2'b10;
    localparam logic [1:0] SR_SHL  = 2'b01;
    localparam logic [1:0] SR_LOAD = 2'b11;

    // True for the five ops that actually move bits.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op <= 3'd4);
    endfunction

    // 110 and 111 are the only unassigned codes.
    function automatic logic is_illegal_op(input logic [2:0] op);
        return (op[2] && op[1]);
    endfunction

endpackage

// File: rtl/shift_sequencer.sv
// Purpose : drives a 16-bit universal shift register through a multi-bit shift/rotate.
// Latency : done asserted amount+1 cycles after the start edge (1 cycle for amount 0, PASS, illegal).
// Backpressure: start is ignored whenever busy=1; one operation in flight at a time.
//
// Ports:
//   clock, reset         single rising-edge clock, synchronous active-high reset
//   start/op/amount/operand  request, sampled only in IDLE
//   busy, done, err      status; err qualifies done for opcodes 110/111
//   result               passthrough of sr_out, valid while done=1
//   sr_enable, sr_s0, sr_s1, sr_lsi, sr_rsi, sr_in   controls to the shift register
//   sr_out               shift register output, used for rotate/arith feedback
module shift_sequencer
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             sr_enable,
    output logic             sr_s0,
    output logic             sr_s1,
    output logic             sr_lsi,
    output logic             sr_rsi,
    output logic [WIDTH-1:0] sr_in,
    input  logic [WIDTH-1:0] sr_out
);

    sr_state_e        r_state;
    sr_state_e        w_next;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_amount;
    logic [WIDTH-1:0] r_operand;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       w_mode;
    logic             w_skip_shift;

    // PASS and illegal ops go straight from LOAD to DONE regardless of amount.
    assign w_skip_shift = !is_shift_op(r_op) || (r_amount == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_amount  <= '0;
            r_operand <= '0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op      <= op;
                        r_amount  <= amount;
                        r_operand <= operand;
                    end
                end
                ST_LOAD:  r_cnt <= r_amount;
                ST_SHIFT: r_cnt <= r_cnt - CNT_W'(1);
                default:  ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_LOAD;
            ST_LOAD:  w_next = w_skip_shift ? ST_DONE : ST_SHIFT;
            // cnt holds the number of steps still to take including this one.
            ST_SHIFT: if (r_cnt == CNT_W'(1)) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Register controls decode from state and latched op only.
    always_comb begin
        sr_enable = 1'b0;
        w_mode    = SR_HOLD;
        sr_lsi    = 1'b0;
        sr_rsi    = 1'b0;
        sr_in     = '0;
        case (r_state)
            ST_LOAD: begin
                sr_enable = 1'b1;
                w_mode    = SR_LOAD;
                sr_in     = r_operand;
            end
            ST_SHIFT: begin
                sr_enable = 1'b1;
                case (r_op)
                    OP_LSL: w_mode = SR_SHL;
                    OP_ROL: begin
                        w_mode = SR_SHL;
                        sr_lsi = sr_out[WIDTH-1];
                    end
                    OP_LSR: w_mode = SR_SHR;
                    OP_ASR: begin
                        w_mode = SR_SHR;
                        sr_rsi = sr_out[WIDTH-1];
                    end
                    OP_ROR: begin
                        w_mode = SR_SHR;
                        sr_rsi = sr_out[0];
                    end
                    default: w_mode = SR_HOLD;
                endcase
            end
            default: ;
        endcase
    end

    assign {sr_s0, sr_s1} = w_mode;
    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);
    assign err    = done && is_illegal_op(r_op);
    assign result = sr_out;

endmodule

// File: tb/tb_shift_sequencer.sv
// Purpose : directed bench for shift_sequencer wired to a behavioural 16-bit universal shift register.
// Latency : checks done timing relative to the start edge for each operation.
// Backpressure: exercises start held high while busy.
module tb_shift_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [3:0]  amount;
    logic [15:0] operand;
    logic        busy, done, err;
    logic [15:0] result;
    logic        sr_enable, sr_s0, sr_s1, sr_lsi, sr_rsi;
    logic [15:0] sr_in;
    logic [15:0] sr_q;

    int errors = 0;
    int checks = 0;

    shift_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .amount    (amount),
        .operand   (operand),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result    (result),
        .sr_enable (sr_enable),
        .sr_s0     (sr_s0),
        .sr_s1     (sr_s1),
        .sr_lsi    (sr_lsi),
        .sr_rsi    (sr_rsi),
        .sr_in     (sr_in),
        .sr_out    (sr_q)
    );

    // Sibling universal shift register (no reset), modes as {s0,s1}.
    always_ff @(posedge clock) begin
        if (sr_enable) begin
            case ({sr_s0, sr_s1})
                2'b11:   sr_q <= sr_in;
                2'b10:   sr_q <= {sr_rsi, sr_q[15:1]};
                2'b01:   sr_q <= {sr_q[14:0], sr_lsi};
                default: sr_q <= sr_q;
            endcase
        end
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issues one request and measures it; comparisons are made by the callers.
    task automatic do_op(input logic [2:0] o, input logic [3:0] a, input logic [15:0] d,
                         output int lat, output logic [15:0] res, output logic e,
                         output logic post_busy, output logic post_done);
        @(negedge clock);
        start = 1'b1; op = o; amount = a; operand = d;
        @(posedge clock);
        #1 start = 1'b0;
        lat = -1; res = '0; e = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = i; res = result; e = err;
                break;
            end
        end
        @(posedge clock);
        #1;
        post_busy = busy;
        post_done = done;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = '0; amount = '0; operand = '0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({busy, done, err, sr_enable, sr_s0, sr_s1, sr_lsi, sr_rsi} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {busy, done, err, sr_enable, sr_s0, sr_s1, sr_lsi, sr_rsi});
        end
        checks++;
        if (sr_in !== 16'h0000) begin
            errors++;
            $display("FAIL reset_sr_in: got %h expected 0000", sr_in);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_lsl();
        int lat;
        logic [15:0] res;
        logic e;
        @(negedge clock);
        start = 1'b1; op = 3'b000; amount = 4'd4; operand = 16'hA5A5;
        @(posedge clock);
        #1 start = 1'b0;
        checks++;
        if ({busy, sr_enable, sr_s0, sr_s1} !== 4'b1111) begin
            errors++;
            $display("FAIL lsl_load_ctrl: got %b expected 1111", {busy, sr_enable, sr_s0, sr_s1});
        end
        checks++;
        if (sr_in !== 16'hA5A5) begin
            errors++;
            $display("FAIL lsl_load_sr_in: got %h expected a5a5", sr_in);
        end
        @(posedge clock);
        #1;
        checks++;
        if ({sr_enable, sr_s0, sr_s1, sr_lsi, sr_rsi} !== 5'b10100) begin
            errors++;
            $display("FAIL lsl_shift_ctrl: got %b expected 10100",
                     {sr_enable, sr_s0, sr_s1, sr_lsi, sr_rsi});
        end
        lat = -1; res = '0; e = 1'b1;
        for (int i = 2; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = i; res = result; e = err;
                break;
            end
        end
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL lsl_latency: got %0d expected 5", lat);
        end
        checks++;
        if (res !== 16'h5A50) begin
            errors++;
            $display("FAIL lsl_result: got %h expected 5a50", res);
        end
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("FAIL lsl_err: got %b expected 0", e);
        end
        @(posedge clock);
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL lsl_after_done: got busy,done=%b expected 00", {busy, done});
        end
    endtask

    task automatic test_shift_modes();
        logic [2:0]  ops  [5] = '{3'b010, 3'b001, 3'b100, 3'b011, 3'b000};
        logic [3:0]  amts [5] = '{4'd3, 4'd15, 4'd1, 4'd15, 4'd1};
        logic [15:0] opnd [5] = '{16'h8010, 16'hFFFF, 16'h0001, 16'h0001, 16'h8001};
        logic [15:0] expv [5] = '{16'hF002, 16'h0001, 16'h8000, 16'h8000, 16'h0002};
        int          expl [5] = '{4, 16, 2, 16, 2};
        int lat;
        logic [15:0] res;
        logic e, pb, pd;
        for (int k = 0; k < 5; k++) begin
            do_op(ops[k], amts[k], opnd[k], lat, res, e, pb, pd);
            checks++;
            if (res !== expv[k] || e !== 1'b0) begin
                errors++;
                $display("FAIL mode%0d_result: got %h err=%b expected %h err=0", k, res, e, expv[k]);
            end
            checks++;
            if (lat !== expl[k]) begin
                errors++;
                $display("FAIL mode%0d_latency: got %0d expected %0d", k, lat, expl[k]);
            end
            checks++;
            if ({pb, pd} !== 2'b00) begin
                errors++;
                $display("FAIL mode%0d_after_done: got %b expected 00", k, {pb, pd});
            end
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        logic first_done;
        logic [15:0] res;
        @(negedge clock);
        start = 1'b1; op = 3'b001; amount = 4'd0; operand = 16'h1234;
        @(posedge clock);          // request sampled
        #1;
        @(posedge clock);          // start still high in LOAD
        #1;
        first_done = done;
        res = result;
        ndone = done ? 1 : 0;
        @(posedge clock);          // start still high in DONE
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_after_done: got busy=%b expected 0", busy);
        end
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            if (done) ndone++;
        end
        checks++;
        if (first_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_latency: got done=%b at 1 edge expected 1", first_done);
        end
        checks++;
        if (res !== 16'h1234) begin
            errors++;
            $display("FAIL b2b_result: got %h expected 1234", res);
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d expected 1", ndone);
        end
    endtask

    task automatic test_reset_mid();
        int ndone;
        int lat;
        logic [15:0] res;
        logic e, pb, pd;
        @(negedge clock);
        start = 1'b1; op = 3'b000; amount = 4'd8; operand = 16'h0001;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        checks++;
        if ({busy, done, sr_enable} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_state: got busy,done,en=%b expected 000", {busy, done, sr_enable});
        end
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock);
            #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL midreset_no_done: got %0d done pulses expected 0", ndone);
        end
        do_op(3'b000, 4'd1, 16'h0003, lat, res, e, pb, pd);
        checks++;
        if (res !== 16'h0006 || e !== 1'b0) begin
            errors++;
            $display("FAIL midreset_next_result: got %h err=%b expected 0006 err=0", res, e);
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL midreset_next_latency: got %0d expected 2", lat);
        end
    endtask

    task automatic test_illegal();
        int lat;
        logic [15:0] res;
        logic e, pb, pd;
        do_op(3'b110, 4'd7, 16'hBEEF, lat, res, e, pb, pd);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL illegal_latency: got %0d expected 1", lat);
        end
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL illegal_err: got %b expected 1", e);
        end
        checks++;
        if (res !== 16'hBEEF) begin
            errors++;
            $display("FAIL illegal_result: got %h expected beef", res);
        end
        checks++;
        if ({pb, pd} !== 2'b00) begin
            errors++;
            $display("FAIL illegal_after_done: got %b expected 00", {pb, pd});
        end
        do_op(3'b101, 4'd9, 16'h0F0F, lat, res, e, pb, pd);
        checks++;
        if (lat !== 1 || res !== 16'h0F0F || e !== 1'b0) begin
            errors++;
            $display("FAIL pass_op: got lat=%0d res=%h err=%b expected lat=1 res=0f0f err=0",
                     lat, res, e);
        end
    endtask

    initial begin
        test_reset();
        test_lsl();
        test_shift_modes();
        test_back_to_back();
        test_reset_mid();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
